// File: rtl/shuffler_ctrl.sv
// Sequencing controller for the radix-3^2 FFT shuffler stage: input-side frame FSM,
// lagged output-side phase counters, mux select decode and frame status.
module shuffler_ctrl #(
    parameter int SEG = 90,
    parameter int OFS = 178
) (
    input  logic clk2,
    input  logic rst,
    input  logic start,
    input  logic en,
    output logic sel1,
    output logic sel2,
    output logic sel,
    output logic sel4,
    output logic sel7,
    output logic busy,
    output logic out_valid,
    output logic frame_done
);

    localparam int CW = (SEG > 1) ? $clog2(SEG) : 1;
    localparam int LW = (OFS > 1) ? $clog2(OFS) : 1;
    localparam logic [CW-1:0] SEG_LAST = CW'(SEG - 1);
    localparam logic [LW-1:0] LAG_LAST = LW'(OFS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] in_cnt;
    logic [1:0]    in_ph;
    logic          pend;
    logic [LW-1:0] lag;
    logic          lag_act;
    logic [CW-1:0] out_cnt;
    logic [1:0]    out_ph;
    logic          out_act;

    logic in_end;
    logic out_end;
    logic lag_hit;
    logic launch;
    logic restart;

    assign in_end  = (state == RUN) && (in_ph == 2'd2) && (in_cnt == SEG_LAST);
    assign out_end = out_act && (out_ph == 2'd2) && (out_cnt == SEG_LAST);
    assign lag_hit = lag_act && (lag == LAG_LAST);
    // A start in FLUSH behaves like one in IDLE; the output side is left untouched.
    assign launch  = (state != RUN) && start;
    assign restart = in_end && (pend || start);

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            in_cnt <= '0;
            in_ph  <= 2'd0;
            pend   <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        in_cnt <= '0;
                        in_ph  <= 2'd0;
                    end
                end
                RUN: begin
                    if (in_end) begin
                        in_cnt <= '0;
                        in_ph  <= 2'd0;
                        pend   <= 1'b0;
                        if (!restart) begin
                            state <= FLUSH;
                        end
                    end else begin
                        if (start) begin
                            pend <= 1'b1;
                        end
                        if (in_cnt == SEG_LAST) begin
                            in_cnt <= '0;
                            in_ph  <= in_ph + 2'd1;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (start) begin
                        state  <= RUN;
                        in_cnt <= '0;
                        in_ph  <= 2'd0;
                    end else if ((!out_act || out_end) && !lag_act) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            lag     <= '0;
            lag_act <= 1'b0;
        end else if (en) begin
            if (launch || restart) begin
                lag     <= '0;
                lag_act <= 1'b1;
            end else if (lag_act) begin
                if (lag == LAG_LAST) begin
                    lag_act <= 1'b0;
                end else begin
                    lag <= lag + 1'b1;
                end
            end
        end
    end

    // The lag expiry of a follow-on frame lands on the previous frame's last sample,
    // so zeroing the counters there gives a gap-free output stream.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
            out_ph  <= 2'd0;
            out_act <= 1'b0;
        end else if (en) begin
            if (lag_hit) begin
                out_act <= 1'b1;
                out_cnt <= '0;
                out_ph  <= 2'd0;
            end else if (out_act) begin
                if (out_end) begin
                    out_act <= 1'b0;
                end else if (out_cnt == SEG_LAST) begin
                    out_cnt <= '0;
                    out_ph  <= out_ph + 2'd1;
                end else begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
        end
    end

    assign sel1       = (state == RUN) && (in_ph == 2'd1);
    assign sel2       = (state == RUN) && (in_ph == 2'd2);
    assign sel        = out_act && (out_ph != 2'd0);
    assign sel4       = out_act && (out_ph == 2'd0);
    assign sel7       = out_act && (out_ph == 2'd2);
    assign out_valid  = out_act;
    assign frame_done = out_end;
    assign busy       = (state != IDLE) || lag_act || out_act;

endmodule

// File: tb/tb_shuffler_ctrl.sv
// Directed bench for shuffler_ctrl with SEG=4, OFS=6; expected windows are hand-derived
// per cycle n, where cycle n is the period following the n-th sampling edge after start.
module tb_shuffler_ctrl;

    localparam int SEG = 4;
    localparam int OFS = 6;

    logic clk2 = 1'b0;
    logic rst;
    logic start;
    logic en;
    logic sel1, sel2, sel, sel4, sel7, busy, out_valid, frame_done;

    int total = 0;
    int bad = 0;
    int fd_count;

    shuffler_ctrl #(.SEG(SEG), .OFS(OFS)) dut (
        .clk2(clk2),
        .rst(rst),
        .start(start),
        .en(en),
        .sel1(sel1),
        .sel2(sel2),
        .sel(sel),
        .sel4(sel4),
        .sel7(sel7),
        .busy(busy),
        .out_valid(out_valid),
        .frame_done(frame_done)
    );

    always #5 clk2 = ~clk2;

    function automatic logic inw(input int n, input int lo, input int hi);
        return (n >= lo) && (n <= hi);
    endfunction

    // Bit order: {sel1, sel2, sel, sel4, sel7, busy, out_valid, frame_done}
    function automatic logic [7:0] expSingle(input int n);
        return {inw(n, 5, 8), inw(n, 9, 12), inw(n, 11, 18), inw(n, 7, 10),
                inw(n, 15, 18), inw(n, 1, 18), inw(n, 7, 18), (n == 18)};
    endfunction

    function automatic logic [7:0] expB2B(input int n);
        return {inw(n, 5, 8) | inw(n, 17, 20), inw(n, 9, 12) | inw(n, 21, 24),
                inw(n, 11, 18) | inw(n, 23, 30), inw(n, 7, 10) | inw(n, 19, 22),
                inw(n, 15, 18) | inw(n, 27, 30), inw(n, 1, 30), inw(n, 7, 30),
                (n == 18) || (n == 30)};
    endfunction

    // Edges 8..10 stalled: cycle 8 is held through 11, later cycles slide by 3.
    function automatic logic [7:0] expStall(input int n);
        return {inw(n, 5, 11), inw(n, 12, 15), inw(n, 14, 21), inw(n, 7, 13),
                inw(n, 18, 21), inw(n, 1, 21), inw(n, 7, 21), (n == 21)};
    endfunction

    task automatic applyStimulus(input logic s, input logic e);
        start = s;
        en    = e;
        @(posedge clk2);
        @(negedge clk2);
    endtask

    task automatic checkOutput(input string tag, input int n, input logic [7:0] expv);
        logic [7:0] obs;
        obs = {sel1, sel2, sel, sel4, sel7, busy, out_valid, frame_done};
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s cycle %0d: observed=%b expected=%b", tag, n, obs, expv);
        end
    endtask

    task automatic runSingle(input string tag);
        for (int k = 0; k <= 21; k++) begin
            applyStimulus(k == 0, 1'b1);
            checkOutput(tag, k + 1, expSingle(k + 1));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        en    = 1'b1;
        @(negedge clk2);
        checkOutput("reset_held", 0, 8'h00);
        @(negedge clk2);
        checkOutput("reset_held_start", 0, 8'h00);
        rst   = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("reset_release", k, 8'h00);
        end

        $display("[TB] single frame");
        runSingle("single");

        $display("[TB] back-to-back frames");
        for (int k = 0; k <= 33; k++) begin
            applyStimulus((k == 0) || (k == 5), 1'b1);
            checkOutput("b2b", k + 1, expB2B(k + 1));
        end

        $display("[TB] overflow request");
        fd_count = 0;
        for (int k = 0; k <= 33; k++) begin
            applyStimulus((k == 0) || (k == 3) || (k == 4), 1'b1);
            checkOutput("overflow", k + 1, expB2B(k + 1));
            if (frame_done === 1'b1) fd_count++;
        end
        total++;
        assert (fd_count === 2) else begin
            bad++;
            $error("[TB] FAIL overflow_done_count: observed=%0d expected=2", fd_count);
        end

        $display("[TB] stall");
        for (int k = 0; k <= 24; k++) begin
            applyStimulus(k == 0, !((k >= 8) && (k <= 10)));
            checkOutput("stall", k + 1, expStall(k + 1));
        end

        $display("[TB] mid-frame reset");
        for (int k = 0; k <= 8; k++) begin
            applyStimulus(k == 0, 1'b1);
            checkOutput("pre_reset", k + 1, expSingle(k + 1));
        end
        start = 1'b0;
        #2 rst = 1'b1;
        #1 checkOutput("midrst_async", 9, 8'h00);
        @(negedge clk2);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1);
        checkOutput("midrst_idle", 0, 8'h00);
        runSingle("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
